// File: rtl/dac_wave_ctrl.sv
// Waveform playback controller: buffers packed DDR sample pairs and replays them to a DAC
// with arm/trigger/stop control, loop counting and an idle code when no sample is valid.
module dac_wave_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DW     = 14
) (
  input  logic              clk_400m,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [4*DW-1:0]   wr_data,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [15:0]       cfg_loops,
  input  logic [DW-1:0]     cfg_idle,
  input  logic              start,
  input  logic              trig,
  input  logic              stop,
  output logic [DW-1:0]     dac1_h,
  output logic [DW-1:0]     dac1_l,
  output logic [DW-1:0]     dac2_h,
  output logic [DW-1:0]     dac2_l,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StPlay = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [15:0]       loops_q, loops_d;
  logic [15:0]       loop_cnt_q, loop_cnt_d;
  logic              issue;

  logic [4*DW-1:0]   mem [2**ADDR_W];
  logic [4*DW-1:0]   rd_q;
  logic              v1_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    loops_d    = loops_q;
    loop_cnt_d = loop_cnt_q;
    issue      = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_d   = cfg_len;
            loops_d = cfg_loops;
            state_d = StArm;
          end
        end
        StArm: begin
          if (trig) begin
            addr_d     = '0;
            loop_cnt_d = '0;
            state_d    = StPlay;
          end
        end
        StPlay: begin
          issue = 1'b1;
          if (addr_q == len_q) begin
            addr_d     = '0;
            loop_cnt_d = loop_cnt_q + 16'd1;
            // loops == 0 means free-running until stop
            if (loops_q != 16'd0 && loop_cnt_q == loops_q - 16'd1) begin
              state_d = StDone;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_400m) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      loops_q    <= '0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      loops_q    <= loops_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  // Buffer is not reset; non-blocking read and write give read-first on collision.
  always_ff @(posedge clk_400m) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[addr_q];
  end

  // Stage 1 tags the read data; stage 2 is the output register, loaded with the idle
  // code whenever the tag is clear or a stop flushes the pipe.
  always_ff @(posedge clk_400m) begin
    if (rst) begin
      v1_q   <= 1'b0;
      dac1_h <= '0;
      dac1_l <= '0;
      dac2_h <= '0;
      dac2_l <= '0;
    end else begin
      v1_q <= issue;
      if (v1_q && !stop) begin
        {dac1_h, dac1_l, dac2_h, dac2_l} <= rd_q;
      end else begin
        dac1_h <= cfg_idle;
        dac1_l <= cfg_idle;
        dac2_h <= cfg_idle;
        dac2_l <= cfg_idle;
      end
    end
  end

  assign busy  = (state_q == StArm) || (state_q == StPlay);
  assign done  = (state_q == StDone);
  assign state = state_q;

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// Randomized bench for dac_wave_ctrl: every cycle is compared against a playback model that
// expands each armed run into its full address sequence and delays samples by two cycles.
`timescale 1ns/1ps
module tb_dac_wave_ctrl;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DW     = 14;
  localparam int unsigned EW     = 4 * DW;

  logic              clk_400m = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [EW-1:0]     wr_data;
  logic [ADDR_W-1:0] cfg_len;
  logic [15:0]       cfg_loops;
  logic [DW-1:0]     cfg_idle;
  logic              start, trig, stop;
  logic [DW-1:0]     dac1_h, dac1_l, dac2_h, dac2_l;
  logic              busy, done;
  logic [1:0]        state;

  dac_wave_ctrl #(.ADDR_W(ADDR_W), .DW(DW)) dut (
    .clk_400m (clk_400m),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cfg_len  (cfg_len),
    .cfg_loops(cfg_loops),
    .cfg_idle (cfg_idle),
    .start    (start),
    .trig     (trig),
    .stop     (stop),
    .dac1_h   (dac1_h),
    .dac1_l   (dac1_l),
    .dac2_h   (dac2_h),
    .dac2_l   (dac2_l),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #1.25 clk_400m = ~clk_400m;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 armed, 2 playing, 3 done.
  int            m_st = 0;
  int            m_len = 0, m_loops = 0;
  int            seq[$];
  logic [EW-1:0] m_mem [256];
  logic [EW-1:0] m_rd;
  logic          m_v1 = 1'b0;
  logic [EW-1:0] m_out = '0;

  function automatic void add_pass();
    for (int a = 0; a <= m_len; a++) seq.push_back(a);
  endfunction

  task automatic model_step();
    bit iss;
    int a;
    if (rst) begin
      m_st  = 0;
      m_v1  = 1'b0;
      m_out = '0;
      seq.delete();
    end else begin
      iss   = (m_st == 2) && !stop;
      m_out = (m_v1 && !stop) ? m_rd : {4{cfg_idle}};
      if (iss) begin
        a    = seq.pop_front();
        m_rd = m_mem[a];
      end
      m_v1 = iss;
      if (stop) begin
        m_st = 0;
        seq.delete();
      end else begin
        case (m_st)
          0: if (start) begin
            m_len   = int'(cfg_len);
            m_loops = int'(cfg_loops);
            m_st    = 1;
          end
          1: if (trig) begin
            seq.delete();
            if (m_loops == 0) add_pass();
            else for (int l = 0; l < m_loops; l++) add_pass();
            m_st = 2;
          end
          2: if (seq.size() == 0) begin
            if (m_loops == 0) add_pass();
            else m_st = 3;
          end
          default: m_st = 0;
        endcase
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_400m);
    #0.5;
    check_eq("dac", 64'({dac1_h, dac1_l, dac2_h, dac2_l}), 64'(m_out));
    check_eq("state", 64'(state), 64'(m_st));
    check_eq("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
    check_eq("done", 64'(done), 64'(m_st == 3));
  endtask

  task automatic write_entry(input int a, input logic [EW-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic arm_and_trig(input int len, input int loops);
    cfg_len = ADDR_W'(len); cfg_loops = 16'(loops);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    trig = 1'b1; tick(); trig = 1'b0;
  endtask

  int n_done, n_not_busy;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cfg_len = '0; cfg_loops = '0;
    cfg_idle = 14'h2000; start = 1'b0; trig = 1'b0; stop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) write_entry(i, {$urandom, $urandom});
    repeat (2) tick();

    // Two passes over entries 0..3, then a single done pulse and idle code.
    arm_and_trig(3, 2);
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) n_done++;
    end
    check_eq("done_pulses", 64'(n_done), 64'd1);

    // Continuous alternation between entries 0 and 1.
    arm_and_trig(1, 0);
    n_done = 0; n_not_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done) n_done++;
      if (!busy) n_not_busy++;
    end
    check_eq("cont_done", 64'(n_done), 64'd0);
    check_eq("cont_busy", 64'(n_not_busy), 64'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();

    // Stop five cycles into playback while trig is held.
    cfg_len = 8'd7; cfg_loops = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    trig = 1'b1; tick();
    repeat (5) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_state", 64'(state), 64'd0);
    check_eq("stop_out", 64'({dac1_h, dac1_l, dac2_h, dac2_l}), {8'h0, {4{14'h2000}}});
    trig = 1'b0; tick();
    check_eq("stop_out2", 64'({dac1_h, dac1_l, dac2_h, dac2_l}), {8'h0, {4{14'h2000}}});
    check_eq("stop_nodone", 64'(done), 64'd0);

    // Start together with stop in idle stays idle; start during playback is ignored.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("start_stop", 64'(state), 64'd0);
    arm_and_trig(3, 3);
    repeat (3) tick();
    cfg_len = 8'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();

    // Config change during playback and writes to the address being read.
    arm_and_trig(7, 3);
    cfg_len = 8'd2; cfg_loops = 16'd1;
    for (int i = 0; i < 30; i++) begin
      wr_en = 1'b0;
      if (m_st == 2 && seq.size() > 0 && (i % 3) == 1) begin
        wr_en = 1'b1; wr_addr = ADDR_W'(seq[0]); wr_data = {$urandom, $urandom};
      end
      tick();
    end
    wr_en = 1'b0;

    // Reset in the middle of playback.
    arm_and_trig(5, 0);
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_out", 64'({dac1_h, dac1_l, dac2_h, dac2_l}), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    repeat (3) tick();

    // Randomized control and buffer traffic.
    for (int i = 0; i < 2000; i++) begin
      start     = ($urandom % 6) == 0;
      stop      = ($urandom % 50) == 0;
      trig      = ($urandom % 3) == 0;
      wr_en     = ($urandom % 2) == 0;
      wr_addr   = ADDR_W'($urandom % 8);
      wr_data   = {$urandom, $urandom};
      cfg_len   = ADDR_W'($urandom % 6);
      cfg_loops = 16'($urandom % 4);
      if (($urandom % 16) == 0) cfg_idle = DW'($urandom);
      tick();
    end
    start = 1'b0; stop = 1'b0; trig = 1'b0; wr_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dac_wave_ctrl.md
DAC_WAVE_CTRL -- requirements
Module: dac_wave_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8: waveform buffer address width (2^ADDR_W entries).
REQ-002 SHALL provide parameter DW, default 14: DAC sample width.
REQ-003 SHALL have port clk_400m  in  1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  in  1: buffer write strobe.
REQ-006 SHALL have port wr_addr  in  ADDR_W: buffer write address.
REQ-007 SHALL have port wr_data  in  4*DW: entry packed {dac1_h, dac1_l, dac2_h, dac2_l}, MSB first.
REQ-008 SHALL have port cfg_len  in  ADDR_W: playback length minus 1.
REQ-009 SHALL have port cfg_loops  in  16: repeat count; 0 = continuous.
REQ-010 SHALL have port cfg_idle  in  DW: code driven when no valid sample.
REQ-011 SHALL have port start  in  1: arm request (pulse).
REQ-012 SHALL have port trig  in  1: playback trigger (level).
REQ-013 SHALL have port stop  in  1: abort request (pulse).
REQ-014 SHALL have ports dac1_h, dac1_l, dac2_h, dac2_l  out  DW each: registered DDR sample halves to the DAC output stage.
REQ-015 SHALL have port busy  out  1: high in ARM or PLAY.
REQ-016 SHALL have port done  out  1: one-cycle pulse on natural completion.
REQ-017 SHALL have port state  out  2: IDLE=0, ARM=1, PLAY=2, DONE=3.

Function
REQ-018 SHALL hold a 2^ADDR_W x 4*DW buffer with synchronous write and 1-cycle synchronous read, read-first on same-address collision; writes accepted in every state.
REQ-019 SHALL in IDLE, on start=1 and stop=0, latch cfg_len and cfg_loops and go to ARM; start ignored in other states.
REQ-020 SHALL in ARM, on first cycle with trig=1, go to PLAY with address counter 0 and loop counter 0.
REQ-021 SHALL in PLAY advance the address counter by 1 each cycle; at address == latched len, wrap to 0 and increment the loop counter.
REQ-022 SHALL, when latched loops != 0 and a wrap occurs with loop counter == loops-1, go to DONE instead of continuing; DONE lasts exactly 1 cycle, asserts done, then IDLE.
REQ-023 SHALL never terminate PLAY on its own when latched loops == 0.
REQ-024 SHALL with latched len 0 replay entry 0 every cycle.
REQ-025 SHALL tag each issued read with a valid bit through a 2-stage pipeline; entry at address k appears on outputs exactly 2 cycles after the cycle the counter held k.
REQ-026 SHALL drive all four outputs = cfg_idle on any cycle whose pipeline valid bit is 0.
REQ-027 SHALL on stop=1 in any state go to IDLE next cycle and clear both valid stages, so outputs = cfg_idle from the cycle after stop is sampled; done not asserted.
REQ-028 SHALL give stop priority over start and trig in the same cycle.
REQ-029 SHALL ignore cfg_len/cfg_loops changes outside the IDLE->ARM latch.
REQ-030 SHALL drain the last two issued samples normally after DONE (no flush).

Reset
REQ-031 SHALL on rst=1 set state IDLE, counters 0, valid stages 0, done 0, busy 0, all sample outputs 0; buffer contents not reset.
REQ-032 SHALL let rst override all inputs, including mid-PLAY, with outputs = cfg_idle from the second cycle after rst deasserts.

Verification
REQ-033 SHALL verify: buffer entries 0..3 written, cfg_len=3, cfg_loops=2, start then trig -> entries 0,1,2,3,0,1,2,3 on outputs starting 2 cycles after PLAY entry, done pulse 1 cycle, then cfg_idle.
REQ-034 SHALL verify: cfg_loops=0, cfg_len=1 -> alternating entries 0,1 for 1000 cycles, busy stays 1, done never asserts.
REQ-035 SHALL verify: stop 5 cycles into PLAY, same cycle as trig held -> state IDLE next cycle, outputs = cfg_idle (0x2000) the following cycle, done=0.
REQ-036 SHALL verify: start and stop together in IDLE -> remains IDLE; start during PLAY -> ignored, playback unaffected.
REQ-037 SHALL verify: cfg_len changed 7->2 during PLAY -> wrap still at 7; write to address being read -> old data output that pass, new data next pass.
REQ-038 SHALL verify: rst asserted mid-PLAY -> all outputs 0, state 0, busy 0 next cycle.
